// File: rtl/conv_disp_pkg.sv
// Shared types and geometry helpers for the conv window dispatcher.
package conv_disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Output feature map side length; 0 when the geometry is unusable.
    function automatic int out_size(input int n, input int f, input int s, input int p);
        int span;
        span = n - f + 2 * p;
        if (s < 1 || span < 0) begin
            return 0;
        end
        return span / s + 1;
    endfunction

    // Number of window jobs in one layer.
    function automatic int total_jobs(input int n, input int f, input int nf,
                                      input int s, input int p);
        int o;
        o = out_size(n, f, s, p);
        return o * o * nf;
    endfunction

endpackage

// File: rtl/lsb_prio_enc.sv
// Lowest-set-bit priority encoder: index of the lowest requesting bit plus an any flag.
module lsb_prio_enc #(
    parameter  int W  = 64,
    localparam int IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  req,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Scan upward and latch the first set bit found.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int unsigned i = 0; i < W; i++) begin
            if (req[i] && !any) begin
                idx = IW'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/conv_window_dispatcher.sv
// Conv-layer job scheduler: walks (filt, oy, ox) and dispatches one window job per
// cycle to the lowest-index free MAC unit, then waits for all jobs to retire.
module conv_window_dispatcher
    import conv_disp_pkg::*;
#(
    parameter  int N     = 32,
    parameter  int F     = 3,
    parameter  int NF    = 4,
    parameter  int S     = 1,
    parameter  int P     = 0,
    parameter  int NMULT = 64,
    parameter  int CW    = 8,
    localparam int UW    = (NMULT > 1) ? $clog2(NMULT) : 1,
    localparam int FW    = (NF > 1) ? $clog2(NF) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 start,
    input  logic [NMULT-1:0]     unit_busy,
    input  logic [NMULT-1:0]     unit_done,
    output logic                 job_valid,
    output logic [UW-1:0]        job_unit,
    output logic [FW-1:0]        job_filt,
    output logic [CW-1:0]        job_oy,
    output logic [CW-1:0]        job_ox,
    output logic signed [CW:0]   job_row,
    output logic signed [CW:0]   job_col,
    output logic                 busy,
    output logic                 done
);

    localparam int OUT   = out_size(N, F, S, P);
    localparam int TOTAL = total_jobs(N, F, NF, S, P);
    localparam int OW    = $clog2(NMULT + 1);

    localparam logic [CW-1:0]        O_LAST = CW'(OUT - 1);
    localparam logic [FW-1:0]        F_LAST = FW'(NF - 1);
    localparam logic signed [CW:0]   S_W    = (CW + 1)'(S);
    localparam logic signed [CW:0]   P_W    = (CW + 1)'(P);

    // Reject geometries the walk counters cannot represent.
    if (S < 1) begin : g_bad_stride
        $error("conv_window_dispatcher: stride S must be >= 1");
    end
    if (P < 0 || P > F - 1) begin : g_bad_pad
        $error("conv_window_dispatcher: padding P must be in 0..F-1");
    end
    if (OUT < 1 || TOTAL < 1) begin : g_bad_out
        $error("conv_window_dispatcher: output size must be >= 1");
    end
    if (N + P >= (1 << CW)) begin : g_bad_cw
        $error("conv_window_dispatcher: CW too narrow for N+P");
    end

    state_e                  state_q, state_d;
    logic [CW-1:0]           ox_q, ox_d;
    logic [CW-1:0]           oy_q, oy_d;
    logic [FW-1:0]           filt_q, filt_d;
    logic [NMULT-1:0]        reserved_q, reserved_d;
    logic [OW-1:0]           outstanding_q, outstanding_d;
    logic                    job_valid_q, job_valid_d;
    logic [UW-1:0]           job_unit_q, job_unit_d;
    logic [FW-1:0]           job_filt_q, job_filt_d;
    logic [CW-1:0]           job_oy_q, job_oy_d;
    logic [CW-1:0]           job_ox_q, job_ox_d;
    logic signed [CW:0]      job_row_q, job_row_d;
    logic signed [CW:0]      job_col_q, job_col_d;

    logic [NMULT-1:0]        free;
    logic [UW-1:0]           grant_idx;
    logic                    grant_any;
    logic [NMULT-1:0]        grant_mask;
    logic                    dispatch;
    logic [OW-1:0]           retire_cnt;

    // Window top-left in image space: o*S - P, may be negative with padding.
    function automatic logic signed [CW:0] base_coord(input logic [CW-1:0] o);
        return $signed({1'b0, o}) * S_W - P_W;
    endfunction

    // A unit is free only once the pool has released it and no dispatch is pending on it.
    always_comb begin
        free = ~unit_busy & ~reserved_q;
    end

    lsb_prio_enc #(.W(NMULT)) u_free_enc (
        .req (free),
        .idx (grant_idx),
        .any (grant_any)
    );

    // Count retirements that hit a reserved unit; others are spurious and ignored.
    always_comb begin
        retire_cnt = '0;
        for (int unsigned i = 0; i < NMULT; i++) begin
            retire_cnt = retire_cnt + OW'(unit_done[i] & reserved_q[i]);
        end
    end

    // Next-state, walk counters, reservation bookkeeping and registered job fields.
    always_comb begin
        state_d       = state_q;
        ox_d          = ox_q;
        oy_d          = oy_q;
        filt_d        = filt_q;
        job_valid_d   = 1'b0;
        job_unit_d    = job_unit_q;
        job_filt_d    = job_filt_q;
        job_oy_d      = job_oy_q;
        job_ox_d      = job_ox_q;
        job_row_d     = job_row_q;
        job_col_d     = job_col_q;
        grant_mask    = '0;
        dispatch      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (grant_any) begin
                    dispatch    = 1'b1;
                    grant_mask  = NMULT'(1) << grant_idx;
                    job_valid_d = 1'b1;
                    job_unit_d  = grant_idx;
                    job_filt_d  = filt_q;
                    job_oy_d    = oy_q;
                    job_ox_d    = ox_q;
                    job_row_d   = base_coord(oy_q);
                    job_col_d   = base_coord(ox_q);
                    if (ox_q == O_LAST) begin
                        ox_d = '0;
                        if (oy_q == O_LAST) begin
                            oy_d = '0;
                            if (filt_q == F_LAST) begin
                                filt_d  = '0;
                                state_d = ST_DRAIN;
                            end else begin
                                filt_d = filt_q + FW'(1);
                            end
                        end else begin
                            oy_d = oy_q + CW'(1);
                        end
                    end else begin
                        ox_d = ox_q + CW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (outstanding_q == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        reserved_d    = (reserved_q & ~unit_done) | grant_mask;
        outstanding_d = outstanding_q + OW'(dispatch) - retire_cnt;

        // Abort wins over everything: forget the layer and any in-flight units.
        if (!en) begin
            state_d       = ST_IDLE;
            ox_d          = '0;
            oy_d          = '0;
            filt_d        = '0;
            reserved_d    = '0;
            outstanding_d = '0;
            job_valid_d   = 1'b0;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            ox_q          <= '0;
            oy_q          <= '0;
            filt_q        <= '0;
            reserved_q    <= '0;
            outstanding_q <= '0;
            job_valid_q   <= 1'b0;
            job_unit_q    <= '0;
            job_filt_q    <= '0;
            job_oy_q      <= '0;
            job_ox_q      <= '0;
            job_row_q     <= '0;
            job_col_q     <= '0;
        end else begin
            state_q       <= state_d;
            ox_q          <= ox_d;
            oy_q          <= oy_d;
            filt_q        <= filt_d;
            reserved_q    <= reserved_d;
            outstanding_q <= outstanding_d;
            job_valid_q   <= job_valid_d;
            job_unit_q    <= job_unit_d;
            job_filt_q    <= job_filt_d;
            job_oy_q      <= job_oy_d;
            job_ox_q      <= job_ox_d;
            job_row_q     <= job_row_d;
            job_col_q     <= job_col_d;
        end
    end

    // Status decodes straight from the state register.
    always_comb begin
        busy = (state_q != ST_IDLE);
        done = (state_q == ST_DONE);
    end

    assign job_valid = job_valid_q;
    assign job_unit  = job_unit_q;
    assign job_filt  = job_filt_q;
    assign job_oy    = job_oy_q;
    assign job_ox    = job_ox_q;
    assign job_row   = job_row_q;
    assign job_col   = job_col_q;

endmodule

// File: tb/tb_conv_window_dispatcher.sv
// Randomized bench for conv_window_dispatcher against a job-index reference model.
module tb_conv_window_dispatcher;

    localparam int N      = 8;
    localparam int F      = 3;
    localparam int NF     = 2;
    localparam int S      = 2;
    localparam int P      = 1;
    localparam int NMULT  = 4;
    localparam int CW     = 8;
    localparam int UW     = 2;
    localparam int FW     = 1;
    localparam int OUT    = (N - F + 2 * P) / S + 1;
    localparam int TOTAL  = OUT * OUT * NF;
    localparam int LAYERS = 300;
    localparam int BUDGET = 2000;

    logic                clk = 1'b0;
    logic                rst;
    logic                en;
    logic                start;
    logic [NMULT-1:0]    unit_busy;
    logic [NMULT-1:0]    unit_done;
    logic                job_valid;
    logic [UW-1:0]       job_unit;
    logic [FW-1:0]       job_filt;
    logic [CW-1:0]       job_oy;
    logic [CW-1:0]       job_ox;
    logic signed [CW:0]  job_row;
    logic signed [CW:0]  job_col;
    logic                busy;
    logic                done;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: phase 0 idle, 1 issuing, 2 waiting for retire, 3 finishing.
    int               m_phase;
    int               m_k;
    logic [NMULT-1:0] m_rsv;
    int               p_valid, p_unit, p_k, p_busy, p_done;

    // Pool model and per-layer knobs.
    int  timer [NMULT];
    int  obs_jobs, obs_done;
    bit  fixed_lat, noise, spur;

    always #5 clk = ~clk;

    conv_window_dispatcher #(
        .N(N), .F(F), .NF(NF), .S(S), .P(P), .NMULT(NMULT), .CW(CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .start     (start),
        .unit_busy (unit_busy),
        .unit_done (unit_done),
        .job_valid (job_valid),
        .job_unit  (job_unit),
        .job_filt  (job_filt),
        .job_oy    (job_oy),
        .job_ox    (job_ox),
        .job_row   (job_row),
        .job_col   (job_col),
        .busy      (busy),
        .done      (done)
    );

    task automatic check_eq(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One cycle at the falling edge: check last edge's outputs, drive inputs, advance model.
    task automatic step(input logic en_i, input logic start_i, input logic [NMULT-1:0] extra_busy);
        logic [NMULT-1:0] b, d, free, nrsv;
        int nphase, nk, u, jf, joy, jox, r;

        check_eq("job_valid", int'(job_valid), p_valid);
        check_eq("busy", int'(busy), p_busy);
        check_eq("done", int'(done), p_done);
        if (p_valid == 1 && job_valid) begin
            jf  = p_k / (OUT * OUT);
            r   = p_k % (OUT * OUT);
            joy = r / OUT;
            jox = r % OUT;
            check_eq("job_unit", int'(job_unit), p_unit);
            check_eq("job_filt", int'(job_filt), jf);
            check_eq("job_oy", int'(job_oy), joy);
            check_eq("job_ox", int'(job_ox), jox);
            check_eq("job_row", int'(job_row), joy * S - P);
            check_eq("job_col", int'(job_col), jox * S - P);
        end
        if (job_valid) begin
            obs_jobs++;
            timer[job_unit] = fixed_lat ? 3 : $urandom_range(2, 6);
        end
        if (done) obs_done++;

        for (int i = 0; i < NMULT; i++) begin
            d[i] = (timer[i] == 1);
            b[i] = (timer[i] > 1);
        end
        b = b | extra_busy;
        if (spur && $urandom_range(0, 5) == 0) begin
            u = $urandom_range(0, NMULT - 1);
            if (timer[u] == 0 && !m_rsv[u]) d[u] = 1'b1;
        end
        en        = en_i;
        start     = start_i;
        unit_busy = b;
        unit_done = d;
        for (int i = 0; i < NMULT; i++) begin
            if (timer[i] > 0) timer[i]--;
        end

        p_valid = 0;
        nphase  = m_phase;
        nk      = m_k;
        nrsv    = m_rsv & ~d;
        if (!en_i) begin
            nphase = 0;
            nk     = 0;
            nrsv   = '0;
        end else begin
            case (m_phase)
                0: if (start_i) nphase = 1;
                1: begin
                    free = ~b & ~m_rsv;
                    if (free != '0) begin
                        u = -1;
                        for (int i = NMULT - 1; i >= 0; i--) if (free[i]) u = i;
                        p_valid = 1;
                        p_unit  = u;
                        p_k     = m_k;
                        nrsv[u] = 1'b1;
                        if (m_k == TOTAL - 1) begin
                            nk     = 0;
                            nphase = 2;
                        end else begin
                            nk = m_k + 1;
                        end
                    end
                end
                2: if (m_rsv == '0) nphase = 3;
                default: nphase = 0;
            endcase
        end
        m_phase = nphase;
        m_k     = nk;
        m_rsv   = nrsv;
        p_busy  = (nphase != 0) ? 1 : 0;
        p_done  = (nphase == 3) ? 1 : 0;
        @(negedge clk);
    endtask

    initial begin
        int cyc, storm_at, abort_at, gap;
        bit aborted;
        logic [NMULT-1:0] xb;
        logic en_i;

        rst = 1'b1; en = 1'b0; start = 1'b0; unit_busy = '0; unit_done = '0;
        m_phase = 0; m_k = 0; m_rsv = '0;
        p_valid = 0; p_unit = 0; p_k = 0; p_busy = 0; p_done = 0;
        for (int i = 0; i < NMULT; i++) timer[i] = 0;
        fixed_lat = 1'b1; noise = 1'b0; spur = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_job_valid", int'(job_valid), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_job_unit", int'(job_unit), 0);
        check_eq("rst_job_row", int'(job_row), 0);
        check_eq("rst_job_col", int'(job_col), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int layer = 0; layer < LAYERS; layer++) begin
            fixed_lat = (layer == 0);
            noise     = (layer > 0) && ($urandom_range(0, 1) == 1);
            spur      = (layer > 0) && ($urandom_range(0, 1) == 1);
            storm_at  = (layer == 1 || (layer > 1 && $urandom_range(0, 3) == 0)) ? $urandom_range(3, 15) : -1;
            abort_at  = (layer == 2) ? 5 :
                        ((layer > 2 && $urandom_range(0, 5) == 0) ? $urandom_range(1, TOTAL - 1) : -1);
            obs_jobs  = 0;
            obs_done  = 0;
            aborted   = 1'b0;

            step(1'b1, 1'b1, '0);
            cyc = 0;
            while (m_phase != 0 && cyc < BUDGET) begin
                en_i = 1'b1;
                if (abort_at >= 0 && m_phase == 1 && m_k >= abort_at) begin
                    en_i    = 1'b0;
                    aborted = 1'b1;
                end
                xb = '0;
                if (storm_at >= 0 && cyc >= storm_at && cyc < storm_at + 10) xb = '1;
                else if (noise) begin
                    for (int i = 0; i < NMULT; i++) xb[i] = ($urandom_range(0, 3) == 0);
                end
                step(en_i, ($urandom_range(0, 15) == 0), xb);
                cyc++;
            end
            check_eq("layer_in_budget", (cyc < BUDGET) ? 1 : 0, 1);
            check_eq("layer_jobs", obs_jobs, aborted ? abort_at : TOTAL);
            check_eq("layer_done_pulses", obs_done, aborted ? 0 : 1);

            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                step(($urandom_range(0, 3) != 0), 1'b0, '0);
            end
        end
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
